// File: rtl/spi_slave_counter_rx_if.sv
// SPI pins plus the decoded-value outputs of the counter receiver.
// The master modport is the far-end SPI master / consumer view, slave is the receiver.
interface spi_slave_counter_rx_if #(
  parameter int DATA_W = 14
);
  logic              sclk;
  logic              mosi;
  logic              ss;
  logic              miso;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              o_frame_err;
  logic              o_busy;

  modport master (
    output sclk, mosi, ss,
    input  miso, o_data, o_valid, o_frame_err, o_busy
  );

  modport slave (
    input  sclk, mosi, ss,
    output miso, o_data, o_valid, o_frame_err, o_busy
  );
endinterface

// File: rtl/spi_slave_counter_rx.sv
// SPI slave receiver for the 14-bit counter link (CPOL=0/CPHA=0, MSB first).
// SCLK/MOSI/SS are synchronized into clk, a 16-bit frame is deserialized while
// SS is low, validated when SS rises, and the last good value is echoed on MISO.
//
// state | meaning
// IDLE  | waiting for a fresh SS falling edge
// RECV  | SS low, sampling MOSI on SCLK rise, shifting echo on SCLK fall
// CHECK | one cycle: validate bit count and padding, update output or flag error
module spi_slave_counter_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 14
) (
  input logic clk,
  input logic reset,
  spi_slave_counter_rx_if.slave bus
);

  localparam int FRAME_W = 16;
  localparam int PAD_W   = FRAME_W - DATA_W;
  localparam logic [4:0] CNT_FULL    = 5'd16;
  localparam logic [4:0] CNT_OVERRUN = 5'd17;
  localparam logic [1:0] FILL_DONE   = 2'(SYNC_STAGES);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic sclk_s, mosi_s, ss_s;
  logic sclk_d, mosi_d, ss_d;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [1:0] fill_cnt;
  logic armed;

  state_t             state;
  logic [FRAME_W-1:0] shift_reg;
  logic [FRAME_W-1:0] echo_reg;
  logic [FRAME_W-1:0] echo_load;
  logic [4:0]         bit_cnt;
  logic [DATA_W-1:0]  data_r;
  logic               valid_r, err_r, busy_r, miso_r;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign echo_load = {{PAD_W{1'b0}}, data_r};

  // Synchronizer chains; reset to the idle bus levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.ss};
    end
  end

  // Edge detection with registered single-cycle strobes; MOSI delayed to stay aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_d    <= 1'b0;
      mosi_d    <= 1'b0;
      ss_d      <= 1'b1;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      ss_rise   <= 1'b0;
      ss_fall   <= 1'b0;
    end else begin
      sclk_d    <= sclk_s;
      mosi_d    <= mosi_s;
      ss_d      <= ss_s;
      sclk_rise <= sclk_s & ~sclk_d;
      sclk_fall <= ~sclk_s & sclk_d;
      ss_rise   <= ss_s & ~ss_d;
      ss_fall   <= ~ss_s & ss_d;
    end
  end

  // Arm only after the sync chain has refilled from the pin and SS is seen high,
  // so an SS already low at reset release cannot fake a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_cnt <= '0;
      armed    <= 1'b0;
    end else begin
      if (fill_cnt != FILL_DONE) fill_cnt <= fill_cnt + 2'd1;
      if (fill_cnt == FILL_DONE && ss_s) armed <= 1'b1;
    end
  end

  // Receive FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      echo_reg  <= '0;
      bit_cnt   <= '0;
      data_r    <= '0;
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
      miso_r    <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall && armed) begin
            state     <= RECV;
            busy_r    <= 1'b1;
            bit_cnt   <= '0;
            shift_reg <= '0;
            echo_reg  <= echo_load;
            miso_r    <= echo_load[FRAME_W-1];
          end
        end
        RECV: begin
          if (sclk_rise) begin
            shift_reg <= {shift_reg[FRAME_W-2:0], mosi_d};
            if (bit_cnt != CNT_OVERRUN) bit_cnt <= bit_cnt + 5'd1;
          end
          if (sclk_fall) begin
            echo_reg <= {echo_reg[FRAME_W-2:0], 1'b0};
            miso_r   <= echo_reg[FRAME_W-2];
          end
          // A sample taken in this same cycle lands before CHECK looks at it.
          if (ss_rise) begin
            state  <= CHECK;
            busy_r <= 1'b0;
            miso_r <= 1'b0;
          end
        end
        CHECK: begin
          state <= IDLE;
          if (bit_cnt == CNT_FULL && shift_reg[FRAME_W-1:DATA_W] == '0) begin
            data_r  <= shift_reg[DATA_W-1:0];
            valid_r <= 1'b1;
          end else begin
            err_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_data      = data_r;
  assign bus.o_valid     = valid_r;
  assign bus.o_frame_err = err_r;
  assign bus.o_busy      = busy_r;
  assign bus.miso        = miso_r;

endmodule

// File: tb/tb_spi_slave_counter_rx.sv
// Bench for spi_slave_counter_rx: directed frame table, reset-mid-frame sequence,
// and random frames checked against a frame-level reference model.
module tb_spi_slave_counter_rx;

  localparam int DATA_W = 14;

  logic clk = 1'b0;
  logic reset;

  spi_slave_counter_rx_if #(.DATA_W(DATA_W)) bus();

  spi_slave_counter_rx #(.SYNC_STAGES(2), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int v_cnt = 0;
  int e_cnt = 0;
  int both_cnt = 0;
  logic [13:0] model_data;

  typedef struct {
    logic [23:0] data;
    int          nbits;
    logic        exp_ok;
    logic [13:0] exp_data;
    string       name;
  } vec_t;

  vec_t tbl[9];

  // Strobe counters.
  always @(negedge clk) begin
    if (bus.o_valid) v_cnt++;
    if (bus.o_frame_err) e_cnt++;
    if (bus.o_valid && bus.o_frame_err) both_cnt++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, output logic m);
    bus.mosi = b;
    repeat (8) @(negedge clk);
    bus.sclk = 1'b1;
    m = bus.miso;
    repeat (8) @(negedge clk);
    bus.sclk = 1'b0;
  endtask

  // One complete SS-framed transfer plus all per-frame checks.
  task automatic do_frame(input string name, input logic [23:0] data, input int nbits,
                          input logic exp_ok, input logic [13:0] exp_data);
    logic [23:0] got, want, e24;
    logic m, busy_mid;
    int lat, v0, e0;
    v0 = v_cnt;
    e0 = e_cnt;
    e24 = {2'b00, model_data, 8'h00};
    want = '0;
    got = '0;
    busy_mid = 1'b0;
    for (int i = 0; i < nbits; i++) want = {want[22:0], e24[23-i]};
    bus.ss = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      send_bit(data[nbits-1-i], m);
      got = {got[22:0], m};
      if (i == 0) busy_mid = bus.o_busy;
    end
    if (nbits == 0) begin
      repeat (42) @(negedge clk);
      busy_mid = bus.o_busy;
    end
    repeat (8) @(negedge clk);
    bus.ss = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.o_valid || bus.o_frame_err) begin
        lat = k;
        break;
      end
    end
    repeat (12) @(negedge clk);
    chk({name, "_latency"}, lat, 5);
    chk({name, "_valid_pulses"}, v_cnt - v0, exp_ok ? 1 : 0);
    chk({name, "_err_pulses"}, e_cnt - e0, exp_ok ? 0 : 1);
    chk({name, "_data"}, bus.o_data, exp_data);
    chk({name, "_miso_echo"}, got, want);
    chk({name, "_busy_during"}, busy_mid, 1);
    chk({name, "_busy_after"}, bus.o_busy, 0);
    chk({name, "_miso_idle"}, bus.miso, 0);
    if (exp_ok) model_data = exp_data;
  endtask

  initial begin
    logic m;
    logic [23:0] rd;
    int nb, v0, e0;
    logic ok;
    logic [15:0] fr;

    tbl[0] = '{24'h001234, 16, 1'b1, 14'h1234, "nominal"};
    tbl[1] = '{24'h000000, 16, 1'b1, 14'h0000, "b2b_zero"};
    tbl[2] = '{24'h003FFF, 16, 1'b1, 14'h3FFF, "b2b_max"};
    tbl[3] = '{24'h001234, 16, 1'b1, 14'h1234, "echo_max"};
    tbl[4] = '{24'h000012, 8,  1'b0, 14'h1234, "short"};
    tbl[5] = '{24'h123456, 24, 1'b0, 14'h1234, "overrun"};
    tbl[6] = '{24'h00C001, 16, 1'b0, 14'h1234, "padding"};
    tbl[7] = '{24'h000005, 16, 1'b1, 14'h0005, "after_pad"};
    tbl[8] = '{24'h000000, 0,  1'b0, 14'h0005, "zero_len"};

    reset = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.ss = 1'b1;
    model_data = '0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("reset_data", bus.o_data, 0);
    chk("reset_valid", bus.o_valid, 0);
    chk("reset_err", bus.o_frame_err, 0);
    chk("reset_busy", bus.o_busy, 0);
    chk("reset_miso", bus.miso, 0);

    for (int i = 0; i < 9; i++)
      do_frame(tbl[i].name, tbl[i].data, tbl[i].nbits, tbl[i].exp_ok, tbl[i].exp_data);

    // Reset in the middle of frame 0x2A55, released with SS still low.
    fr = 16'h2A55;
    bus.ss = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 9; i++) send_bit(fr[15-i], m);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_data", bus.o_data, 0);
    chk("midrst_busy", bus.o_busy, 0);
    chk("midrst_miso", bus.miso, 0);
    model_data = '0;
    v0 = v_cnt;
    e0 = e_cnt;
    for (int i = 9; i < 16; i++) send_bit(fr[15-i], m);
    chk("midrst_busy_tail", bus.o_busy, 0);
    repeat (8) @(negedge clk);
    bus.ss = 1'b1;
    repeat (30) @(negedge clk);
    chk("midrst_no_valid", v_cnt - v0, 0);
    chk("midrst_no_err", e_cnt - e0, 0);
    chk("midrst_data_hold", bus.o_data, 0);
    do_frame("post_reset", 24'h002A55, 16, 1'b1, 14'h2A55);

    // Random frames against the frame-level model.
    for (int t = 0; t < 40; t++) begin
      rd = 24'($urandom);
      if ($urandom_range(0, 9) < 7) nb = 16;
      else nb = int'($urandom_range(0, 20));
      if (nb == 16 && $urandom_range(0, 3) != 0) rd[15:14] = 2'b00;
      ok = (nb == 16) && (rd[15:14] == 2'b00);
      do_frame($sformatf("rand%0d", t), rd, nb, ok, ok ? rd[13:0] : model_data);
    end

    chk("strobes_never_both", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
